// File: rtl/calculo_preco.sv
// Weight x unit-price calculator: serial shift-add multiply, +500 rounding, restoring
// division by 1000, saturating to a 14-bit centimos result.
module calculo_preco (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] peso_gramas,
  input  logic [13:0] preco_kg,
  output logic [13:0] centimos,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_RND,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [4:0]  MUL_LAST = 5'd13;
  localparam logic [4:0]  DIV_LAST = 5'd27;
  localparam logic [10:0] DIVISOR  = 11'd1000;
  localparam logic [27:0] HALF     = 28'd500;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [27:0] acc_q, acc_d;       // product, then dividend shifting out / quotient shifting in
  logic [27:0] mcand_q, mcand_d;
  logic [13:0] mplier_q, mplier_d;
  logic [9:0]  rem_q, rem_d;
  logic [13:0] cent_q, cent_d;
  logic        ovf_q, ovf_d;

  logic [10:0] trial;
  logic        qbit;
  logic [27:0] quotient;

  assign trial    = {rem_q, acc_q[27]};
  assign qbit     = (trial >= DIVISOR);
  assign quotient = {acc_q[26:0], qbit};

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    cent_d   = cent_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {14'd0, peso_gramas};
          mplier_d = preco_kg;
          acc_d    = '0;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end

      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == MUL_LAST) begin
          cnt_d   = '0;
          state_d = S_RND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_RND: begin
        acc_d   = acc_q + HALF;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end

      S_DIV: begin
        rem_d = qbit ? 10'(trial - DIVISOR) : trial[9:0];
        acc_d = quotient;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          // Quotient can reach 268403; anything above 14 bits saturates.
          if (|quotient[27:14]) begin
            cent_d = 14'h3FFF;
            ovf_d  = 1'b1;
          end else begin
            cent_d = quotient[13:0];
            ovf_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      cent_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      cent_q   <= cent_d;
      ovf_q    <= ovf_d;
    end
  end

  assign centimos = cent_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_calculo_preco.sv
// Directed bench for calculo_preco: latency, rounding, saturation, ignored starts,
// reset abort and back-to-back operation; inputs driven and outputs sampled on negedge.
module tb_calculo_preco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] peso_gramas;
  logic [13:0] preco_kg;
  logic [13:0] centimos;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  calculo_preco dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .peso_gramas(peso_gramas),
    .preco_kg   (preco_kg),
    .centimos   (centimos),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One computation: start pulse set on a negedge, k counts following negedges, so the
  // done cycle is k=44 and IDLE is back at k=45. Optional stray start at k=glitch_at.
  task automatic run(input string tag, input logic [13:0] p, input logic [13:0] u,
                     input logic [13:0] exp_c, input logic exp_o,
                     input logic [13:0] prev_c, input int glitch_at);
    int done_at = -1;
    int n_done  = 0;
    @(negedge clk);
    peso_gramas = p;
    preco_kg    = u;
    start       = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) check({tag, "_busy_on"}, busy, 1);
      if (k == 43) check({tag, "_hold_prev"}, centimos, prev_c);
      if (k == glitch_at) begin
        start       = 1'b1;
        peso_gramas = 14'd3333;
        preco_kg    = 14'd7777;
      end else if (k > 1) begin
        peso_gramas = 14'(k * 37);
        preco_kg    = 14'(k * 91);
      end
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k;
          check({tag, "_cent"}, centimos, exp_c);
          check({tag, "_ovf"}, overflow, exp_o);
        end
      end
      if (k == 45) check({tag, "_busy_off"}, busy, 0);
    end
    check({tag, "_latency"}, done_at, 44);
    check({tag, "_ndone"}, n_done, 1);
    check({tag, "_cent_hold"}, centimos, exp_c);
  endtask

  initial begin
    int first_done;
    int last_done;
    int n_done;
    int gap_bad;
    int seen_done;

    rst_n       = 1'b0;
    start       = 1'b0;
    peso_gramas = '0;
    preco_kg    = '0;
    repeat (3) @(negedge clk);
    check("rst_cent", centimos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    run("basic",    14'd1000,  14'd470,   14'd470,   1'b0, 14'd0,     -1);
    run("rnd_up",   14'd1,     14'd500,   14'd1,     1'b0, 14'd470,   -1);
    run("rnd_down", 14'd1,     14'd499,   14'd0,     1'b0, 14'd1,     -1);
    run("sat",      14'd16383, 14'd16383, 14'd16383, 1'b1, 14'd0,     -1);
    run("zero",     14'd0,     14'd9999,  14'd0,     1'b0, 14'd16383, -1);
    run("ignore",   14'd1234,  14'd5678,  14'd7007,  1'b0, 14'd0,     10);

    // Reset during DIV: abandon, no done, outputs cleared immediately.
    @(negedge clk);
    peso_gramas = 14'd2000;
    preco_kg    = 14'd350;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    check("abort_pre_cent", centimos, 7007);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cent", centimos, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_nodone", seen_done, 0);
    check("abort_cent_after", centimos, 0);
    run("post_rst", 14'd2500, 14'd199, 14'd498, 1'b0, 14'd0, -1);

    // start held for 100 edges: launches at 0, 45, 90 -> three dones 45 apart.
    @(negedge clk);
    peso_gramas = 14'd2000;
    preco_kg    = 14'd350;
    start       = 1'b1;
    first_done  = -1;
    last_done   = -1;
    n_done      = 0;
    gap_bad     = 0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 100) start = 1'b0;
      if (done) begin
        n_done++;
        if (centimos !== 14'd700) gap_bad++;
        if (last_done >= 0 && (k - last_done) != 45) gap_bad++;
        if (first_done < 0) first_done = k;
        last_done = k;
      end
    end
    check("b2b_first", first_done, 44);
    check("b2b_count", n_done, 3);
    check("b2b_gap_cent", gap_bad, 0);
    check("b2b_cent", centimos, 700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
